// File: rtl/bus_pkg.sv
// Shared types and constants for the system bus arbiter and its helpers.
package bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GNT_M1 = 2'd1,
    GNT_M2 = 2'd2
  } arb_state_t;

  typedef logic master_id_t;

  localparam master_id_t MST1 = 1'b0;
  localparam master_id_t MST2 = 1'b1;

  localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/arb_hold_timer.sv
// Hold timer for the arbiter: a clearable, saturating up-counter that flags
// the last permitted grant cycle. A LIMIT of 0 means the timer never expires.
module arb_hold_timer #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned CNT_W = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam logic [CNT_W-1:0] CMP_VAL = (LIMIT == 0) ? '0 : CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over increment, and the count sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (LIMIT != 0) && (cnt_q == CMP_VAL);

endmodule

// File: rtl/bus_arbiter.sv
// Two-master system bus arbiter with round-robin fairness, split-transaction
// parking for slave 3, and a hold timeout so that a stuck master cannot keep
// the bus. Every grant is followed by at least one idle cycle.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT,
  parameter int unsigned CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic m1_req,
  input  logic m2_req,
  input  logic txn_done,
  input  logic split,
  input  logic split_release,
  output logic m1_grant,
  output logic m2_grant,
  output logic msel,
  output logic bus_busy,
  output logic split_pending,
  output logic timeout
);

  arb_state_t state_q, state_d;
  master_id_t msel_q, msel_d;
  master_id_t lastOwner_q, lastOwner_d;
  master_id_t parked_q, parked_d;
  master_id_t resumeId_q, resumeId_d;
  logic       splitPending_q, splitPending_d;
  logic       resume_q, resume_d;
  logic       timeout_q, timeout_d;

  logic       timerClear, timerInc, timerExpired;
  logic [1:0] req, liveReq;
  master_id_t owner, winner;
  logic       winnerValid;
  logic       splitTake, releaseTake;

  assign req = {m2_req, m1_req};

  assign liveReq[MST1] = m1_req && !(splitPending_q && (parked_q == MST1));
  assign liveReq[MST2] = m2_req && !(splitPending_q && (parked_q == MST2));

  assign owner       = (state_q == GNT_M2) ? MST2 : MST1;
  assign splitTake   = split && !splitPending_q;
  assign releaseTake = split_release && splitPending_q && !split;

  // Pick who would get the bus if arbitration ran this edge.
  always_comb begin
    winnerValid = 1'b0;
    winner      = MST1;
    if (resume_q && liveReq[resumeId_q]) begin
      winnerValid = 1'b1;
      winner      = resumeId_q;
    end else if (liveReq[MST1] && liveReq[MST2]) begin
      winnerValid = 1'b1;
      winner      = ~lastOwner_q;
    end else if (liveReq[MST1]) begin
      winnerValid = 1'b1;
      winner      = MST1;
    end else if (liveReq[MST2]) begin
      winnerValid = 1'b1;
      winner      = MST2;
    end
  end

  // Next-state logic for grants, split bookkeeping and the timeout pulse.
  always_comb begin
    state_d        = state_q;
    msel_d         = msel_q;
    lastOwner_d    = lastOwner_q;
    parked_d       = parked_q;
    resumeId_d     = resumeId_q;
    splitPending_d = splitPending_q;
    resume_d       = resume_q;
    timeout_d      = 1'b0;
    timerClear     = 1'b0;
    timerInc       = 1'b0;

    case (state_q)
      IDLE: begin
        timerClear = 1'b1;
        resume_d   = 1'b0;
        if (winnerValid) begin
          state_d     = (winner == MST2) ? GNT_M2 : GNT_M1;
          msel_d      = winner;
          lastOwner_d = winner;
        end
      end
      GNT_M1, GNT_M2: begin
        if (splitTake) begin
          parked_d       = owner;
          splitPending_d = 1'b1;
          state_d        = IDLE;
        end else if (txn_done) begin
          state_d = IDLE;
        end else if (timerExpired) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else if (!req[owner]) begin
          state_d = IDLE;
        end else begin
          timerInc = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (releaseTake) begin
      splitPending_d = 1'b0;
      resume_d       = 1'b1;
      resumeId_d     = parked_q;
    end
  end

  // State registers; reset leaves M2 as last owner so M1 wins the first tie.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      msel_q         <= MST1;
      lastOwner_q    <= MST2;
      parked_q       <= MST1;
      resumeId_q     <= MST1;
      splitPending_q <= 1'b0;
      resume_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      msel_q         <= msel_d;
      lastOwner_q    <= lastOwner_d;
      parked_q       <= parked_d;
      resumeId_q     <= resumeId_d;
      splitPending_q <= splitPending_d;
      resume_q       <= resume_d;
      timeout_q      <= timeout_d;
    end
  end

  arb_hold_timer #(
    .LIMIT(TIMEOUT_CYCLES),
    .CNT_W(CNT_W)
  ) u_holdTimer (
    .clk      (clk),
    .rst      (rst),
    .clear_i  (timerClear),
    .inc_i    (timerInc),
    .expired_o(timerExpired)
  );

  assign m1_grant      = (state_q == GNT_M1);
  assign m2_grant      = (state_q == GNT_M2);
  assign msel          = msel_q;
  assign bus_busy      = (state_q != IDLE);
  assign split_pending = splitPending_q;
  assign timeout       = timeout_q;

endmodule
